pong_match_ctrl: RTL and testbench

//  Match sequencer for the pong datapath. Replaces the bare new/play/over loop in the top level.

---
 rtl/pong_match_ctrl.sv | 137 +++++++++++++
 tb/tb_pong_match_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_match_ctrl.sv
// Match sequencer for pong: serve/play/point/game-over flow, scores, rally count
// and frame-timed pauses; freezes pong_graph outside PLAY.
module pong_match_ctrl #(
    parameter int WIN_SCORE    = 5,
    parameter int SERVE_FRAMES = 120,
    parameter int OVER_FRAMES  = 180,
    parameter int SCORE_W      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic [1:0]         btn1,
    input  logic [1:0]         btn2,
    input  logic               hit,
    input  logic               miss_l,
    input  logic               miss_r,
    output logic               graph_still,
    output logic               ball_reload,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [7:0]         rally_cnt,
    output logic               match_over,
    output logic [1:0]         winner,
    output logic [2:0]         state
);

    localparam int TMAX = (SERVE_FRAMES > OVER_FRAMES) ? SERVE_FRAMES : OVER_FRAMES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0]      T_SERVE = TW'(SERVE_FRAMES);
    localparam logic [TW-1:0]      T_OVER  = TW'(OVER_FRAMES);
    localparam logic [TW-1:0]      T_ONE   = TW'(1);
    localparam logic [TW-1:0]      T_ZERO  = '0;
    localparam logic [SCORE_W-1:0] WIN_S   = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] S_ONE   = SCORE_W'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    state_t        st;
    logic [TW-1:0] timer;
    logic [SCORE_W-1:0] s1_inc;
    logic [SCORE_W-1:0] s2_inc;
    logic          any_btn;

    assign s1_inc  = score1 + S_ONE;
    assign s2_inc  = score2 + S_ONE;
    assign any_btn = (btn1 != 2'b00) || (btn2 != 2'b00);
    assign state   = st;

    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= IDLE;
            timer       <= T_ZERO;
            graph_still <= 1'b1;
            ball_reload <= 1'b0;
            score1      <= '0;
            score2      <= '0;
            rally_cnt   <= 8'd0;
            match_over  <= 1'b0;
            winner      <= 2'b00;
        end else begin
            ball_reload <= 1'b0;
            case (st)
                IDLE: begin
                    if (any_btn) begin
                        score1      <= '0;
                        score2      <= '0;
                        rally_cnt   <= 8'd0;
                        winner      <= 2'b00;
                        ball_reload <= 1'b1;
                        timer       <= T_SERVE;
                        st          <= SERVE;
                    end
                end
                SERVE, POINT: begin
                    // Timer was loaded with N on entry, so the tick seen at 1 is the Nth.
                    if (frame_tick) begin
                        if (timer == T_ONE) begin
                            timer       <= T_ZERO;
                            graph_still <= 1'b0;
                            st          <= PLAY;
                        end else begin
                            timer <= timer - T_ONE;
                        end
                    end
                end
                PLAY: begin
                    if (miss_l && miss_r) begin
                        ball_reload <= 1'b1;
                        rally_cnt   <= 8'd0;
                        graph_still <= 1'b1;
                        timer       <= T_SERVE;
                        st          <= POINT;
                    end else if (miss_r || miss_l) begin
                        graph_still <= 1'b1;
                        if (miss_r) score1 <= s1_inc;
                        else        score2 <= s2_inc;
                        if ((miss_r && s1_inc == WIN_S) || (miss_l && s2_inc == WIN_S)) begin
                            winner     <= miss_r ? 2'b01 : 2'b10;
                            match_over <= 1'b1;
                            timer      <= T_OVER;
                            st         <= OVER;
                        end else begin
                            ball_reload <= 1'b1;
                            rally_cnt   <= 8'd0;
                            timer       <= T_SERVE;
                            st          <= POINT;
                        end
                    end else if (hit && rally_cnt != 8'hFF) begin
                        rally_cnt <= rally_cnt + 8'd1;
                    end
                end
                OVER: begin
                    // Hold the final screen for the full pause, then until buttons are released.
                    if (timer != T_ZERO) begin
                        if (frame_tick) timer <= timer - T_ONE;
                    end else if (!any_btn) begin
                        match_over <= 1'b0;
                        st         <= IDLE;
                    end
                end
                default: begin
                    graph_still <= 1'b1;
                    timer       <= T_ZERO;
                    st          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: directed match scenarios plus random play, every cycle
// compared against a frame-counting reference model.
module tb_pong_match_ctrl;

    localparam int WIN_SCORE    = 2;
    localparam int SERVE_FRAMES = 3;
    localparam int OVER_FRAMES  = 4;
    localparam int SCORE_W      = 4;

    localparam int M_IDLE  = 0;
    localparam int M_SERVE = 1;
    localparam int M_PLAY  = 2;
    localparam int M_POINT = 3;
    localparam int M_OVER  = 4;

    logic               clk;
    logic               reset;
    logic               frame_tick;
    logic [1:0]         btn1;
    logic [1:0]         btn2;
    logic               hit;
    logic               miss_l;
    logic               miss_r;
    logic               graph_still;
    logic               ball_reload;
    logic [SCORE_W-1:0] score1;
    logic [SCORE_W-1:0] score2;
    logic [7:0]         rally_cnt;
    logic               match_over;
    logic [1:0]         winner;
    logic [2:0]         state;

    int total;
    int bad;

    pong_match_ctrl #(
        .WIN_SCORE   (WIN_SCORE),
        .SERVE_FRAMES(SERVE_FRAMES),
        .OVER_FRAMES (OVER_FRAMES),
        .SCORE_W     (SCORE_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .btn1       (btn1),
        .btn2       (btn2),
        .hit        (hit),
        .miss_l     (miss_l),
        .miss_r     (miss_r),
        .graph_still(graph_still),
        .ball_reload(ball_reload),
        .score1     (score1),
        .score2     (score2),
        .rally_cnt  (rally_cnt),
        .match_over (match_over),
        .winner     (winner),
        .state      (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // free-running frame tick, one pulse every 10 clocks
    int ft_cnt = 0;
    initial frame_tick = 1'b0;
    always @(negedge clk) begin
        ft_cnt = ft_cnt + 1;
        if (ft_cnt == 10) begin
            frame_tick = 1'b1;
            ft_cnt = 0;
        end else begin
            frame_tick = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: counts pause ticks upward against the required number
    int m_mode, m_seen, m_need, m_s1, m_s2, m_rally, m_win;
    bit m_reload, m_over;
    logic [23:0] exp_q[$];

    task automatic start_pause(input int mode, input int n);
        m_mode = mode;
        m_seen = 0;
        m_need = n;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_mode = M_IDLE; m_seen = 0; m_need = 0;
            m_s1 = 0; m_s2 = 0; m_rally = 0; m_win = 0;
            m_reload = 1'b0; m_over = 1'b0;
        end else begin
            m_reload = 1'b0;
            case (m_mode)
                M_IDLE: begin
                    if (btn1 != 0 || btn2 != 0) begin
                        m_s1 = 0; m_s2 = 0; m_rally = 0; m_win = 0;
                        m_reload = 1'b1;
                        start_pause(M_SERVE, SERVE_FRAMES);
                    end
                end
                M_SERVE, M_POINT: begin
                    if (frame_tick) begin
                        m_seen = m_seen + 1;
                        if (m_seen == m_need) m_mode = M_PLAY;
                    end
                end
                M_PLAY: begin
                    if (miss_l && miss_r) begin
                        m_reload = 1'b1; m_rally = 0;
                        start_pause(M_POINT, SERVE_FRAMES);
                    end else if (miss_l || miss_r) begin
                        if (miss_r) m_s1 = m_s1 + 1;
                        else        m_s2 = m_s2 + 1;
                        if (m_s1 == WIN_SCORE || m_s2 == WIN_SCORE) begin
                            m_win = miss_r ? 1 : 2;
                            m_over = 1'b1;
                            start_pause(M_OVER, OVER_FRAMES);
                        end else begin
                            m_reload = 1'b1; m_rally = 0;
                            start_pause(M_POINT, SERVE_FRAMES);
                        end
                    end else if (hit && m_rally < 255) begin
                        m_rally = m_rally + 1;
                    end
                end
                default: begin
                    if (m_seen < m_need) begin
                        if (frame_tick) m_seen = m_seen + 1;
                    end else if (btn1 == 0 && btn2 == 0) begin
                        m_mode = M_IDLE;
                        m_over = 1'b0;
                    end
                end
            endcase
        end
        exp_q.push_back({3'(m_mode), (m_mode != M_PLAY), m_reload, 4'(m_s1), 4'(m_s2),
                         8'(m_rally), m_over, 2'(m_win)});
    end

    // scoreboard: every cycle the DUT outputs must match the model
    always @(negedge clk) begin
        logic [23:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cycle", {state, graph_still, ball_reload, score1, score2, rally_cnt,
                            match_over, winner}, e);
        end
    end

    // driver tasks
    task automatic press(input logic [1:0] b1, input logic [1:0] b2);
        @(negedge clk);
        btn1 = b1; btn2 = b2;
        @(negedge clk);
        btn1 = 2'b00; btn2 = 2'b00;
    endtask

    task automatic pulse(input logic h, input logic ml, input logic mr);
        @(negedge clk);
        hit = h; miss_l = ml; miss_r = mr;
        @(negedge clk);
        hit = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (state == target) break;
            @(negedge clk);
        end
        check(tag, state, target);
    endtask

    task automatic rand_run(input int n);
        int r;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            btn1   = ($urandom_range(0, 99) < 4) ? 2'($urandom_range(1, 3)) : 2'b00;
            btn2   = ($urandom_range(0, 99) < 4) ? 2'($urandom_range(1, 3)) : 2'b00;
            hit    = ($urandom_range(0, 99) < 15);
            r      = $urandom_range(0, 99);
            miss_l = (r < 4);
            miss_r = (r >= 96) || (r == 0);
            reset  = ($urandom_range(0, 999) == 0);
        end
        @(negedge clk);
        btn1 = 2'b00; btn2 = 2'b00; hit = 1'b0; miss_l = 1'b0; miss_r = 1'b0; reset = 1'b0;
    endtask

    initial begin
        bit tick_seen;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        btn1 = 2'b00; btn2 = 2'b00;
        hit = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", state, 3'd0);
        check("rst_still", graph_still, 1'b1);
        check("rst_scores", {score1, score2}, 8'h00);
        reset = 1'b0;

        // first serve
        press(2'b01, 2'b00);
        check("t1_reload", ball_reload, 1'b1);
        check("t1_serve", state, 3'd1);
        check("t1_still_serve", graph_still, 1'b1);
        wait_state("t1_to_play", 3'd2, 60);
        check("t1_moving", graph_still, 1'b0);
        check("t1_scores", {score1, score2}, 8'h00);

        // rally of three, point to player 1
        repeat (3) pulse(1'b1, 1'b0, 1'b0);
        check("t2_rally", rally_cnt, 8'd3);
        pulse(1'b0, 1'b0, 1'b1);
        check("t2_score1", score1, 4'd1);
        check("t2_point", state, 3'd3);
        check("t2_reload", ball_reload, 1'b1);
        check("t2_rally_clr", rally_cnt, 8'd0);
        wait_state("t2_to_play", 3'd2, 60);

        // double miss replays; hit with miss_l still scores for player 2
        pulse(1'b0, 1'b1, 1'b1);
        check("t3_scores", {score1, score2}, 8'h10);
        check("t3_point", state, 3'd3);
        wait_state("t3_to_play", 3'd2, 60);
        pulse(1'b1, 1'b1, 1'b0);
        check("t3_score2", score2, 4'd1);
        check("t3_point2", state, 3'd3);
        wait_state("t3_to_play2", 3'd2, 60);

        // match point with btn2 held through the game-over pause
        repeat (2) pulse(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        btn2 = 2'b10;
        pulse(1'b1, 1'b0, 1'b1);
        check("t4_score1", score1, 4'd2);
        check("t4_winner", winner, 2'b01);
        check("t4_over", match_over, 1'b1);
        check("t4_rally_held", rally_cnt, 8'd2);
        repeat (70) @(negedge clk);
        check("t4_held", state, 3'd4);
        btn2 = 2'b00;
        @(negedge clk);
        check("t4_idle", state, 3'd0);
        check("t4_over_clr", match_over, 1'b0);

        // rally counter saturation
        press(2'b00, 2'b01);
        check("t6_scores_clr", {score1, score2}, 8'h00);
        wait_state("t6_to_play", 3'd2, 60);
        hit = 1'b1;
        repeat (300) @(negedge clk);
        hit = 1'b0;
        check("t6_rally_sat", rally_cnt, 8'd255);
        check("t6_still_play", state, 3'd2);

        // reset mid-serve after the first of three ticks
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        press(2'b10, 2'b00);
        tick_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            if (frame_tick) begin
                tick_seen = 1'b1;
                break;
            end
        end
        check("t5_tick_seen", tick_seen, 1'b1);
        @(negedge clk);
        check("t5_mid_serve", state, 3'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5_state", state, 3'd0);
        check("t5_outs", {graph_still, ball_reload, score1, score2, rally_cnt, match_over, winner},
              {1'b1, 1'b0, 4'd0, 4'd0, 8'd0, 1'b0, 2'b00});

        rand_run(5000);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
